multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle MIPS control unit; next generation after the single-cycle decoder.
//  An FSM steps each instruction through fetch, decode, execute, memory and writeback.
//  It drives the shared-ALU datapath's control lines per state.
//  It stalls on a memory ready handshake, counts retired instructions and traps on
//  illegal encodings.
// PARAMETERS
//  RET_W       32  width of retired-instruction counter
//  MEM_TIMEOUT 15  max wait cycles for mem_ready (used only with MC_TIMEOUT_EN)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      synchronous active-low reset
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  funct        in   6      IR[5:0]
//  mem_ready    in   1      memory completes access this cycle
//  zero         in   1      ALU zero flag
//  pc_write     out  1      unconditional PC load
//  pc_write_cond out 1      PC load if (zero ^ neg_zero)
//  pc_source    out  2      0=ALU, 1=ALUOut(target), 2=jump addr, 3=rs (jr)
//  ir_write     out  1      latch IR
//  mem_read     out  2      0=none, 1=byte, 2=half, 3=word
//  mem_write    out  2      same size encoding
//  reg_dst      out  2      0=rt, 1=rd, 2=$31
//  mem_to_reg   out  2      0=ALUOut, 1=MDR, 2=PC
//  alu_src_a    out  1      0=PC, 1=rs
//  alu_src_b    out  2      0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
//  alu_op       out  4      0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 lui
//  reg_write    out  1      register file write enable
//  inm          out  1      immediate-format instruction in flight
//  neg_zero     out  1      bne polarity for branch test
//  state        out  4      current FSM state (debug)
//  illegal      out  1      sticky trap flag
//  retired      out  RET_W  instructions completed since reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - state<=FETCH; retired<=0; illegal<=0.
//   - All outputs are 0 while rst_n=0.
//  Outputs are decoded from state. Exceptions: ir_write/pc_write in FETCH,
//   pc_write_cond in BRANCH.
//  FETCH:
//   - mem_read=3, alu_src_a=0, alu_src_b=1, alu_op=0010, pc_source=0.
//   - On mem_ready: ir_write=1, pc_write=1, go to DECODE; else hold.
//  DECODE (1 cycle):
//   - alu_src_a=0, alu_src_b=3, alu_op=0010 (branch target precomputed).
//   - Dispatch: 000000->EXEC_R; addi/andi/ori/slti/lui->EXEC_I;
//     lb/lh/lw/sb/sh/sw->MEMADDR; beq/bne->BRANCH; j/jal->JUMP; else->TRAP.
//  EXEC_R:
//   - funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt -> ALUWB.
//   - funct 001000 (jr): pc_source=3, pc_write=1, no reg write -> FETCH.
//   - Other funct -> TRAP.
//  EXEC_I:
//   - alu_src_a=1, alu_src_b=2, inm=1.
//   - alu_op: addi 0010, andi 0000, ori 0001, slti 0111, lui 1000 -> ALUWB.
//  ALUWB: reg_write=1, mem_to_reg=0, reg_dst=1 (R) or 0 (I) -> FETCH.
//  MEMADDR: alu_src_a=1, alu_src_b=2, alu_op=0010, inm=1 -> MEMRD (loads) / MEMWR (stores).
//  MEMRD: mem_read=size (lb 1, lh 2, lw 3); hold until mem_ready -> MEMWB.
//  MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  MEMWR: mem_write=size (sb 1, sh 2, sw 3); hold until mem_ready -> FETCH.
//  BRANCH:
//   - alu_src_a=1, alu_src_b=0, alu_op=0110, pc_source=1, pc_write_cond=1.
//   - neg_zero=1 for bne -> FETCH.
//  JUMP: pc_source=2, pc_write=1; jal adds reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH.
//  TRAP: illegal<=1; all enables 0; terminal until reset.
//  retired increments on every transition into FETCH from a non-FETCH state
//   (TRAP excluded); wraps modulo 2^RET_W.
//  opcode/funct are sampled combinationally in every state; the datapath holds the IR stable.
//  Reset mid-instruction aborts it with no write, and retired is unchanged before clear.
// CONFIGURATION
//  MC_TIMEOUT_EN defined:
//   - A wait counter runs in FETCH/MEMRD/MEMWR and clears on state change.
//   - If MEM_TIMEOUT cycles pass without mem_ready: go to TRAP, illegal=1.
//  MC_TIMEOUT_EN undefined: waits indefinitely; no counter logic.
// TESTING
//  - Reset, then add $3,$1,$2 with mem_ready=1:
//    FETCH,DECODE,EXEC_R,ALUWB; reg_write=1, reg_dst=1 at cycle 4; retired=1.
//  - lw with mem_ready low 3 cycles in MEMRD:
//    mem_read=3 held 4 cycles; MEMWB mem_to_reg=1; 5 states + stall = 8 cycles.
//  - bne with zero=0: pc_write_cond=1, neg_zero=1, pc_source=1; beq repeated gives neg_zero=0.
//  - jal: JUMP asserts pc_write, reg_write, reg_dst=2, mem_to_reg=2; next state FETCH.
//  - opcode 111111: DECODE->TRAP, illegal=1 held 10 cycles, retired frozen;
//    rst_n=0 clears it and returns to FETCH.
//  - MC_TIMEOUT_EN, mem_ready=0 in FETCH: TRAP after exactly 15 cycles, illegal=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional MC_TIMEOUT_EN adds a memory-wait watchdog that traps after MEM_TIMEOUT cycles.
module multicycle_control #(
   parameter int RET_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   input  logic             zero,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic             ir_write,
   output logic [1:0]       mem_read,
   output logic [1:0]       mem_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_op,
   output logic             reg_write,
   output logic             inm,
   output logic             neg_zero,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_EXEC_I  = 4'd3,
      S_ALUWB   = 4'd4,
      S_MEMADDR = 4'd5,
      S_MEMRD   = 4'd6,
      S_MEMWB   = 4'd7,
      S_MEMWR   = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_TRAP    = 4'd11
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_LUI = 4'b1000;

   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [RET_W-1:0] retired_q, retired_d;

   logic       is_r, is_imm, is_load, is_store;
   logic       is_br, is_jmp, is_bne, is_jal;
   logic       r_ok, is_jr;
   logic [3:0] i_alu_op, r_alu_op;
   logic [1:0] mem_size;

   always_comb begin
      is_r     = (opcode == 6'b000000);
      is_bne   = (opcode == 6'b000101);
      is_jal   = (opcode == 6'b000011);
      is_imm   = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      is_br    = 1'b0;
      is_jmp   = 1'b0;
      i_alu_op = ALU_ADD;
      mem_size = 2'd0;
      case (opcode)
         6'b001000: begin is_imm = 1'b1; i_alu_op = ALU_ADD; end
         6'b001100: begin is_imm = 1'b1; i_alu_op = ALU_AND; end
         6'b001101: begin is_imm = 1'b1; i_alu_op = ALU_OR;  end
         6'b001010: begin is_imm = 1'b1; i_alu_op = ALU_SLT; end
         6'b001111: begin is_imm = 1'b1; i_alu_op = ALU_LUI; end
         6'b100000: begin is_load  = 1'b1; mem_size = 2'd1; end
         6'b100001: begin is_load  = 1'b1; mem_size = 2'd2; end
         6'b100011: begin is_load  = 1'b1; mem_size = 2'd3; end
         6'b101000: begin is_store = 1'b1; mem_size = 2'd1; end
         6'b101001: begin is_store = 1'b1; mem_size = 2'd2; end
         6'b101011: begin is_store = 1'b1; mem_size = 2'd3; end
         6'b000100,
         6'b000101: is_br  = 1'b1;
         6'b000010,
         6'b000011: is_jmp = 1'b1;
         default:   ;
      endcase
   end

   always_comb begin
      r_ok     = 1'b1;
      is_jr    = 1'b0;
      r_alu_op = ALU_AND;
      case (funct)
         6'b100000: r_alu_op = ALU_ADD;
         6'b100010: r_alu_op = ALU_SUB;
         6'b100100: r_alu_op = ALU_AND;
         6'b100101: r_alu_op = ALU_OR;
         6'b101010: r_alu_op = ALU_SLT;
         6'b001000: begin is_jr = 1'b1; r_ok = 1'b0; end
         default:   r_ok = 1'b0;
      endcase
   end

`ifdef MC_TIMEOUT_EN
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   logic [WW-1:0] wait_q, wait_d;
   logic          waiting, timeout;

   always_comb begin
      waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                (state_q == S_MEMWR);
      timeout = waiting && !mem_ready &&
                (wait_q == WW'(MEM_TIMEOUT - 1));
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:   if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               is_r:               state_d = S_EXEC_R;
               is_imm:             state_d = S_EXEC_I;
               is_load | is_store: state_d = S_MEMADDR;
               is_br:              state_d = S_BRANCH;
               is_jmp:             state_d = S_JUMP;
               default:            state_d = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            if (is_jr)     state_d = S_FETCH;
            else if (r_ok) state_d = S_ALUWB;
            else           state_d = S_TRAP;
         end
         S_EXEC_I:  state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_MEMADDR: state_d = is_load ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (mem_ready) state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_TRAP;
      endcase
`ifdef MC_TIMEOUT_EN
      if (timeout) state_d = S_TRAP;
      if (state_d != state_q) wait_d = '0;
      else if (waiting)       wait_d = wait_q + WW'(1);
      else                    wait_d = '0;
`endif
      // an instruction retires whenever control returns to FETCH
      retired_d = retired_q;
      if (state_d == S_FETCH && state_q != S_FETCH)
         retired_d = retired_q + RET_W'(1);
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef MC_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) wait_q <= '0;
      else        wait_q <= wait_d;
   end
`endif

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'd0;
      ir_write      = 1'b0;
      mem_read      = 2'd0;
      mem_write     = 2'd0;
      reg_dst       = 2'd0;
      mem_to_reg    = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = ALU_AND;
      reg_write     = 1'b0;
      inm           = 1'b0;
      neg_zero      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_read  = 2'd3;
            alu_src_b = 2'd1;
            alu_op    = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            if (is_jr) begin
               pc_source = 2'd3;
               pc_write  = 1'b1;
            end else begin
               alu_src_a = 1'b1;
               alu_op    = r_alu_op;
            end
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = i_alu_op;
            inm       = 1'b1;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = is_r ? 2'd1 : 2'd0;
         end
         S_MEMADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = ALU_ADD;
            inm       = 1'b1;
         end
         S_MEMRD: mem_read = mem_size;
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'd1;
         end
         S_MEMWR: mem_write = mem_size;
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_source     = 2'd1;
            neg_zero      = is_bne;
            pc_write_cond = zero ^ is_bne;
         end
         S_JUMP: begin
            pc_source = 2'd2;
            pc_write  = 1'b1;
            if (is_jal) begin
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
            end
         end
         S_TRAP:  ;
         default: ;
      endcase
      if (!rst_n) begin
         {pc_write, pc_write_cond, pc_source, ir_write} = '0;
         {mem_read, mem_write, reg_dst, mem_to_reg}     = '0;
         {alu_src_a, alu_src_b, alu_op}                 = '0;
         {reg_write, inm, neg_zero}                     = '0;
      end
   end

   assign state   = rst_n ? state_q : 4'd0;
   assign illegal = rst_n & illegal_q;
   assign retired = rst_n ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle model, directed + random.
// RET_W is narrowed so the retired counter wraps within the run.
module tb_multicycle_control;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic          mem_ready = 1'b0;
   logic          zero = 1'b0;
   logic          pc_write, pc_write_cond, ir_write;
   logic [1:0]    pc_source, mem_read, mem_write;
   logic [1:0]    reg_dst, mem_to_reg, alu_src_b;
   logic          alu_src_a, reg_write, inm, neg_zero;
   logic [3:0]    alu_op, state;
   logic          illegal;
   logic [RW-1:0] retired;

   always #5 clk = ~clk;

   multicycle_control #(.RET_W(RW), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .inm(inm),
      .neg_zero(neg_zero), .state(state), .illegal(illegal),
      .retired(retired)
   );

   typedef struct packed {
      logic          pcw, pcwc;
      logic [1:0]    pcs;
      logic          irw;
      logic [1:0]    mr, mw, rd, m2r;
      logic          asa;
      logic [1:0]    asb;
      logic [3:0]    aop;
      logic          rw, inm, nz, ill;
      logic [RW-1:0] ret;
   } ctl_t;

   int   n_vec = 0;
   int   n_bad = 0;
   int   count = 0;
   logic ill_m = 1'b0;

   function automatic ctl_t obs();
      ctl_t o;
      o.pcw = pc_write;   o.pcwc = pc_write_cond;
      o.pcs = pc_source;  o.irw = ir_write;
      o.mr = mem_read;    o.mw = mem_write;
      o.rd = reg_dst;     o.m2r = mem_to_reg;
      o.asa = alu_src_a;  o.asb = alu_src_b;
      o.aop = alu_op;     o.rw = reg_write;
      o.inm = inm;        o.nz = neg_zero;
      o.ill = illegal;    o.ret = retired;
      return o;
   endfunction

   function automatic ctl_t base();
      ctl_t e = '0;
      e.ill = ill_m;
      e.ret = RW'(count);
      return e;
   endfunction

   // instruction classes straight from the ISA table
   localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3;
   localparam int C_BR = 4, C_J = 5, C_BAD = 6;

   function automatic int cls(input logic [5:0] op);
      case (op)
         6'h00: return C_R;
         6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f: return C_I;
         6'h20, 6'h21, 6'h23: return C_LD;
         6'h28, 6'h29, 6'h2b: return C_ST;
         6'h04, 6'h05: return C_BR;
         6'h02, 6'h03: return C_J;
         default: return C_BAD;
      endcase
   endfunction

   function automatic logic [1:0] msize(input logic [5:0] op);
      case (op[2:0])
         3'b000: return 2'd1;
         3'b001: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] imm_op(input logic [5:0] op);
      case (op)
         6'h08: return 4'b0010;
         6'h0c: return 4'b0000;
         6'h0d: return 4'b0001;
         6'h0a: return 4'b0111;
         default: return 4'b1000;
      endcase
   endfunction

   // returns 15 for jr, 14 for an unknown funct
   function automatic logic [3:0] r_op(input logic [5:0] fn);
      case (fn)
         6'h20: return 4'b0010;
         6'h22: return 4'b0110;
         6'h24: return 4'b0000;
         6'h25: return 4'b0001;
         6'h2a: return 4'b0111;
         6'h08: return 4'd15;
         default: return 4'd14;
      endcase
   endfunction

   task automatic step(input logic mr, input ctl_t e,
                       input string tag);
      ctl_t o;
      @(negedge clk);
      mem_ready = mr;
      #1;
      o = obs();
      n_vec++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic check_zero(input string tag);
      ctl_t o;
      o = obs();
      n_vec++;
      assert (o === '0 && state === 4'd0) else begin
         n_bad++;
         $error("FAIL %s: observed %h/%0d expected 0/0",
                tag, o, state);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'($urandom);
      #1 check_zero("rst_now");
      @(negedge clk);
      #1 check_zero("rst_held");
      rst_n = 1'b1;
      mem_ready = 1'b0;
      count = 0;
      ill_m = 1'b0;
   endtask

   function automatic ctl_t fetch_e(input logic rdy);
      ctl_t e = base();
      e.mr = 2'd3; e.asb = 2'd1; e.aop = 4'b0010;
      e.irw = rdy; e.pcw = rdy;
      return e;
   endfunction

   task automatic do_fetch(input int sf, input logic [5:0] op,
                           input logic [5:0] fn);
      for (int i = 0; i <= sf; i++) begin
         step(i == sf, fetch_e(i == sf), "fetch");
         if (i == 0) begin
            opcode = op;
            funct = fn;
         end
      end
   endtask

   task automatic do_decode();
      ctl_t e = base();
      e.asb = 2'd3; e.aop = 4'b0010;
      step(1'($urandom), e, "decode");
   endtask

   task automatic trap_hold(input string tag);
      ill_m = 1'b1;
      repeat (10) step(1'($urandom), base(), tag);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int sf, input int sm, input logic z);
      ctl_t e;
      logic [3:0] ro;
      zero = z;
      do_fetch(sf, op, fn);
      do_decode();
      e = base();
      case (cls(op))
         C_R: begin
            ro = r_op(fn);
            if (ro == 4'd15) begin
               e.pcs = 2'd3; e.pcw = 1'b1;
               step(1'($urandom), e, "jr");
            end else begin
               e.asa = 1'b1;
               e.aop = (ro == 4'd14) ? 4'b0000 : ro;
               step(1'($urandom), e, "exec_r");
               if (ro == 4'd14) begin
                  trap_hold("trap_funct");
                  return;
               end
               e = base(); e.rw = 1'b1; e.rd = 2'd1;
               step(1'($urandom), e, "aluwb_r");
            end
         end
         C_I: begin
            e.asa = 1'b1; e.asb = 2'd2; e.inm = 1'b1;
            e.aop = imm_op(op);
            step(1'($urandom), e, "exec_i");
            e = base(); e.rw = 1'b1;
            step(1'($urandom), e, "aluwb_i");
         end
         C_LD, C_ST: begin
            e.asa = 1'b1; e.asb = 2'd2; e.inm = 1'b1;
            e.aop = 4'b0010;
            step(1'($urandom), e, "memaddr");
            e = base();
            if (cls(op) == C_LD) e.mr = msize(op);
            else e.mw = msize(op);
            for (int i = 0; i <= sm; i++)
               step(i == sm, e, cls(op) == C_LD ? "memrd" : "memwr");
            if (cls(op) == C_LD) begin
               e = base(); e.rw = 1'b1; e.m2r = 2'd1;
               step(1'($urandom), e, "memwb");
            end
         end
         C_BR: begin
            e.asa = 1'b1; e.aop = 4'b0110; e.pcs = 2'd1;
            e.nz = (op == 6'h05);
            e.pcwc = z ^ e.nz;
            step(1'($urandom), e, "branch");
         end
         C_J: begin
            e.pcs = 2'd2; e.pcw = 1'b1;
            if (op == 6'h03) begin
               e.rw = 1'b1; e.rd = 2'd2; e.m2r = 2'd2;
            end
            step(1'($urandom), e, "jump");
         end
         default: begin
            trap_hold("trap_op");
            return;
         end
      endcase
      count++;
   endtask

   logic [11:0] tbl [21] = '{
      {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24},
      {6'h00, 6'h25}, {6'h00, 6'h2a}, {6'h00, 6'h08},
      {6'h08, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
      {6'h0a, 6'h00}, {6'h0f, 6'h00}, {6'h20, 6'h00},
      {6'h21, 6'h00}, {6'h23, 6'h00}, {6'h28, 6'h00},
      {6'h29, 6'h00}, {6'h2b, 6'h00}, {6'h04, 6'h00},
      {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
   };

   initial begin
      logic [11:0] pick;
      logic [5:0]  rfn;
      ctl_t        e;
      do_reset();
      run_instr(6'h00, 6'h20, 0, 0, 1'b0);
      run_instr(6'h23, 6'h00, 0, 3, 1'b0);
      run_instr(6'h05, 6'h00, 0, 0, 1'b0);
      run_instr(6'h04, 6'h00, 0, 0, 1'b0);
      run_instr(6'h04, 6'h00, 0, 0, 1'b1);
      run_instr(6'h05, 6'h00, 1, 0, 1'b1);
      run_instr(6'h03, 6'h00, 0, 0, 1'b0);
      run_instr(6'h02, 6'h00, 2, 0, 1'b0);
      run_instr(6'h00, 6'h08, 0, 0, 1'b0);
      run_instr(6'h2b, 6'h00, 0, 2, 1'b0);
      run_instr(6'h0f, 6'h00, 0, 0, 1'b0);
      for (int n = 0; n < 60; n++) begin
         pick = tbl[$urandom_range(20)];
         rfn = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom);
         run_instr(pick[11:6], rfn, $urandom_range(4),
                   $urandom_range(4), 1'($urandom));
      end
      run_instr(6'h00, 6'h01, 0, 0, 1'b0);
      do_reset();
      run_instr(6'h00, 6'h22, 0, 0, 1'b0);
      run_instr(6'h3f, 6'h00, 0, 0, 1'b0);
      do_reset();
      zero = 1'b0;
      do_fetch(0, 6'h20, 6'h00);
      do_decode();
      e = base(); e.asa = 1'b1; e.asb = 2'd2;
      e.inm = 1'b1; e.aop = 4'b0010;
      step(1'b0, e, "ab_memaddr");
      e = base(); e.mr = 2'd1;
      step(1'b0, e, "ab_memrd");
      do_reset();
      run_instr(6'h21, 6'h00, 0, 1, 1'b0);
      run_instr(6'h29, 6'h00, 0, 0, 1'b0);
`ifdef MC_TIMEOUT_EN
      repeat (15) step(1'b0, fetch_e(1'b0), "to_wait");
      ill_m = 1'b1;
      step(1'b0, base(), "to_trap");
      do_reset();
      run_instr(6'h00, 6'h25, 0, 0, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end
endmodule
